// File: rtl/mem_access.sv
// mem_access: memory-access stage between Execute and writeback.
// It takes one instruction at a time. Loads and stores make a single
// outstanding transaction on the data bus. Every instruction then leaves as a
// one-cycle o_valid pulse that carries its Signals bundle. Load data is aligned
// and extended here, so writeback receives final register data in wdata.
//
// Ports:
//   clk, rst                    clock; synchronous active-high reset
//   i_valid / o_ready           instruction handshake from Execute
//   i_signals                   bundle from Execute
//   i_mem_op, i_mem_size        op (0 none, 1 load, 2 store, 3 none), size (0 B, 1 H, 2/3 W)
//   i_mem_signed                sign-extend load result
//   i_addr, i_store_data        byte address, right-justified store data
//   d_req/d_we/d_addr/d_wstrb/d_wdata, d_gnt, d_rvalid, d_rdata   data-memory bus
//   o_valid, o_signals, o_fault one-cycle result to writeback
//
// Build option MEM_MISALIGN_TRAP_EN:
//   defined   - a misaligned load/store is not sent to the bus; it returns at once
//               with o_fault=1 and wback cleared.
//   undefined - a misaligned access rounds down to the natural boundary, and
//               o_fault stays 0.

package mem_access_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic        branch;
        logic [3:0]  cond;
        logic [3:0]  flags;
        logic        wback;
        logic [4:0]  wreg;
        logic [31:0] wdata;
    } signals_t;
endpackage

// state  | meaning
// S_IDLE | ready for a new instruction; non-memory ops complete from here
// S_REQ  | d_req held with latched address/data until d_gnt
// S_WAIT | load granted, waiting for d_rvalid
module mem_access
    import mem_access_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  signals_t    i_signals,
    input  logic [1:0]  i_mem_op,
    input  logic [1:0]  i_mem_size,
    input  logic        i_mem_signed,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_store_data,
    output logic        d_req,
    output logic        d_we,
    output logic [31:0] d_addr,
    output logic [3:0]  d_wstrb,
    output logic [31:0] d_wdata,
    input  logic        d_gnt,
    input  logic        d_rvalid,
    input  logic [31:0] d_rdata,
    output logic        o_valid,
    output signals_t    o_signals,
    output logic        o_fault
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t      state;
    state_t      state_next;
    signals_t    sig_q;
    logic        we_q;
    logic [1:0]  size_q;
    logic        sgn_q;
    logic [31:0] addr_q;
    logic [31:0] sd_q;
    logic        accept;
    logic        is_mem_in;
    logic        trap;
    logic [1:0]  lane;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_data;

    assign o_ready   = (state == S_IDLE);
    assign accept    = i_valid && o_ready;
    assign is_mem_in = (i_mem_op == 2'd1) || (i_mem_op == 2'd2);

`ifdef MEM_MISALIGN_TRAP_EN
    logic misaligned;
    logic fault_q;

    always_comb begin
        case (i_mem_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = i_addr[0];
            default: misaligned = |i_addr[1:0];
        endcase
    end

    assign trap = is_mem_in && misaligned;

    always_ff @(posedge clk) begin
        if (rst) fault_q <= 1'b0;
        else     fault_q <= accept && trap;
    end

    assign o_fault = fault_q;
`else
    assign trap    = 1'b0;
    assign o_fault = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept && is_mem_in && !trap) state_next = S_REQ;
            S_REQ:   if (d_gnt) state_next = we_q ? S_IDLE : S_WAIT;
            S_WAIT:  if (d_rvalid) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Lane is rounded down to the access size. With trapping enabled, a
    // misaligned access never reaches here, so the rounding has no effect.
    always_comb begin
        case (size_q)
            2'd0:    lane = addr_q[1:0];
            2'd1:    lane = {addr_q[1], 1'b0};
            default: lane = 2'd0;
        endcase
    end

    always_comb begin
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wstrb = '0;
        d_wdata = '0;
        if (state == S_REQ) begin
            d_req  = 1'b1;
            d_we   = we_q;
            d_addr = {addr_q[31:2], 2'b00};
            case (size_q)
                2'd0: begin
                    d_wstrb = 4'b0001 << lane;
                    d_wdata = {4{sd_q[7:0]}};
                end
                2'd1: begin
                    d_wstrb = 4'b0011 << lane;
                    d_wdata = {2{sd_q[15:0]}};
                end
                default: begin
                    d_wstrb = 4'hF;
                    d_wdata = sd_q;
                end
            endcase
            if (!we_q) d_wstrb = 4'h0;
        end
    end

    assign rd_byte = d_rdata[{lane, 3'b000} +: 8];
    assign rd_half = d_rdata[{lane[1], 4'b0000} +: 16];

    always_comb begin
        case (size_q)
            2'd0:    load_data = {{24{sgn_q & rd_byte[7]}}, rd_byte};
            2'd1:    load_data = {{16{sgn_q & rd_half[15]}}, rd_half};
            default: load_data = d_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q     <= '0;
            we_q      <= 1'b0;
            size_q    <= 2'd0;
            sgn_q     <= 1'b0;
            addr_q    <= '0;
            sd_q      <= '0;
            o_valid   <= 1'b0;
            o_signals <= '0;
        end else begin
            o_valid <= 1'b0;
            if (accept) begin
                sig_q  <= i_signals;
                we_q   <= (i_mem_op == 2'd2);
                size_q <= i_mem_size;
                sgn_q  <= i_mem_signed;
                addr_q <= i_addr;
                sd_q   <= i_store_data;
                if (!is_mem_in || trap) begin
                    o_valid   <= 1'b1;
                    o_signals <= i_signals;
                    if (trap) o_signals.wback <= 1'b0;
                end
            end
            if (state == S_REQ && d_gnt && we_q) begin
                o_valid   <= 1'b1;
                o_signals <= sig_q;
            end
            if (state == S_WAIT && d_rvalid) begin
                o_valid         <= 1'b1;
                o_signals       <= sig_q;
                o_signals.wdata <= load_data;
            end
        end
    end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: self-checking bench for mem_access. It plays Execute and the
// data memory. A byte-level model computes the expected results, and a
// negedge monitor compares the DUT outputs against that model.
module tb_mem_access;
    import mem_access_pkg::*;

`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic        o_ready;
    signals_t    i_signals;
    logic [1:0]  i_mem_op;
    logic [1:0]  i_mem_size;
    logic        i_mem_signed;
    logic [31:0] i_addr;
    logic [31:0] i_store_data;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [3:0]  d_wstrb;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        o_valid;
    signals_t    o_signals;
    logic        o_fault;

    mem_access dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_signals(i_signals), .i_mem_op(i_mem_op), .i_mem_size(i_mem_size),
        .i_mem_signed(i_mem_signed), .i_addr(i_addr), .i_store_data(i_store_data),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wstrb(d_wstrb),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .o_valid(o_valid), .o_signals(o_signals), .o_fault(o_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        signals_t sig;
        logic     fault;
    } exp_t;

    exp_t        exp_q[$];
    signals_t    last_sig = '0;
    logic [31:0] exp_baddr = '0;
    logic        exp_bwe = 1'b0;
    logic [3:0]  exp_bwstrb = '0;
    logic [31:0] exp_bwdata = '0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          cycle = 0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- model ----------------
    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit misal(input logic [31:0] addr, input logic [1:0] size);
        int a;
        a = int'(addr[1:0]);
        return (a % nbytes(size)) != 0;
    endfunction

    function automatic int eff_lane(input logic [31:0] addr, input logic [1:0] size);
        int a;
        a = int'(addr[1:0]);
        return a - (a % nbytes(size));
    endfunction

    function automatic logic [3:0] m_wstrb(input logic [31:0] addr, input logic [1:0] size);
        logic [3:0] s;
        int ln, n;
        s = '0;
        ln = eff_lane(addr, size);
        n = nbytes(size);
        for (int i = 0; i < 4; i++) if (i >= ln && i < ln + n) s[i] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] sd, input logic [1:0] size);
        logic [31:0] w;
        int n;
        n = nbytes(size);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [31:0] addr,
                                           input logic [1:0] size, input logic sgn);
        longint v;
        int n, ln;
        n = nbytes(size);
        ln = eff_lane(addr, size);
        v = 0;
        for (int k = 0; k < n; k++) v += longint'(rd[8*(ln+k) +: 8]) << (8*k);
        if (sgn && n < 4 && v >= (longint'(1) << (8*n - 1))) v -= (longint'(1) << (8*n));
        return v[31:0];
    endfunction

    function automatic signals_t mk_sig(input logic [31:0] pc, input logic [4:0] wreg,
                                        input logic [31:0] wdata);
        signals_t s;
        s.pc = pc; s.branch = pc[2]; s.cond = pc[7:4]; s.flags = pc[11:8];
        s.wback = 1'b1; s.wreg = wreg; s.wdata = wdata;
        return s;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_o_valid: got 1 expected 0 at cycle %0d", cycle);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("o_signals", o_signals, e.sig);
                    check("o_fault", o_fault, e.fault);
                    last_sig = e.sig;
                end
            end else begin
                check("o_signals_hold", o_signals, last_sig);
            end
            if (d_req) begin
                check("d_addr", d_addr, exp_baddr);
                check("d_we", d_we, exp_bwe);
                check("d_wstrb", d_wstrb, exp_bwstrb);
                if (exp_bwe) check("d_wdata", d_wdata, exp_bwdata);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic run_op(input signals_t sig, input logic [1:0] op, input logic [1:0] size,
                          input logic sgn, input logic [31:0] addr, input logic [31:0] sd,
                          input int gd, input int rd, input logic [31:0] rdata, input bit stray,
                          output int lat, output int nreq, output signals_t osig,
                          output logic ofault, output logic [31:0] baddr,
                          output logic [31:0] bwdata, output logic [3:0] bwstrb,
                          output int vcyc);
        bit is_mem, trap, bus;
        int w, gcyc, rcyc, exp_lat;
        exp_t e;
        w = 0;
        while (!o_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        check("ready_before_issue", o_ready, 1'b1);
        is_mem = (op == 2'd1) || (op == 2'd2);
        trap = is_mem && misal(addr, size) && TRAP_EN;
        bus = is_mem && !trap;
        e.sig = sig;
        e.fault = 1'b0;
        if (trap) begin
            e.sig.wback = 1'b0;
            e.fault = 1'b1;
        end else if (op == 2'd1) begin
            e.sig.wdata = m_load(rdata, addr, size, sgn);
        end
        exp_q.push_back(e);
        if (bus) begin
            exp_baddr  = {addr[31:2], 2'b00};
            exp_bwe    = (op == 2'd2);
            exp_bwstrb = (op == 2'd2) ? m_wstrb(addr, size) : 4'h0;
            exp_bwdata = m_wdata(sd, size);
        end
        i_valid = 1'b1; i_signals = sig; i_mem_op = op; i_mem_size = size;
        i_mem_signed = sgn; i_addr = addr; i_store_data = sd;
        @(posedge clk); #1;
        i_valid = 1'b0;
        gcyc = 1 + gd;
        rcyc = gcyc + 1 + rd;
        exp_lat = !bus ? 1 : (op == 2'd2) ? 2 + gd : 3 + gd + rd;
        lat = -1; nreq = 0; osig = '0; ofault = 1'b0;
        baddr = '0; bwdata = '0; bwstrb = '0; vcyc = 0;
        for (int c = 1; c <= 40; c++) begin
            d_gnt = bus && (c == gcyc);
            d_rvalid = 1'b0;
            d_rdata = 32'h5A5A_5A5A;
            if (bus && op == 2'd1 && c == rcyc) begin
                d_rvalid = 1'b1;
                d_rdata = rdata;
            end else if (stray && c <= gcyc) begin
                d_rvalid = 1'b1;
            end
            @(negedge clk);
            if (d_req) begin
                nreq++;
                baddr = d_addr; bwdata = d_wdata; bwstrb = d_wstrb;
            end
            if (o_valid) begin
                lat = c; osig = o_signals; ofault = o_fault; vcyc = cycle;
                break;
            end
            @(posedge clk); #1;
        end
        d_gnt = 1'b0;
        d_rvalid = 1'b0;
        if (lat < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL op_timeout: got no o_valid expected o_valid within 40 cycles");
        end else begin
            check("latency", lat, exp_lat);
            check("req_cycles", nreq, bus ? gd + 1 : 0);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int lat, nreq, vcyc, vcyc1;
        signals_t osig, s;
        logic ofault;
        logic [31:0] baddr, bwdata;
        logic [3:0] bwstrb;

        rst = 1'b1; i_valid = 1'b0; i_signals = '0; i_mem_op = '0; i_mem_size = '0;
        i_mem_signed = 1'b0; i_addr = '0; i_store_data = '0;
        d_gnt = 1'b0; d_rvalid = 1'b0; d_rdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_o_ready", o_ready, 1'b1);
        check("rst_o_valid", o_valid, 1'b0);
        check("rst_o_fault", o_fault, 1'b0);
        check("rst_o_signals", o_signals, 0);
        check("rst_d_req", d_req, 1'b0);
        check("rst_d_we", d_we, 1'b0);
        check("rst_d_wstrb", d_wstrb, 4'h0);
        idle(1);

        // non-memory op
        s = mk_sig(32'h0000_1000, 5'd3, 32'h0000_1234);
        run_op(s, 2'd0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 0, 0, 32'h0, 1'b0,
               lat, nreq, osig, ofault, baddr, bwdata, bwstrb, vcyc);
        check("nonmem_wdata", osig.wdata, 32'h0000_1234);
        check("nonmem_no_req", nreq, 0);
        idle(1);

        // op 3 behaves as no memory op
        s = mk_sig(32'h0000_1004, 5'd4, 32'h0000_00AB);
        run_op(s, 2'd3, 2'd0, 1'b1, 32'h0000_0203, 32'h0, 0, 0, 32'h0, 1'b0,
               lat, nreq, osig, ofault, baddr, bwdata, bwstrb, vcyc);
        check("op3_latency", lat, 1);
        idle(1);

        // signed / unsigned byte load at 0x103
        s = mk_sig(32'h0000_1008, 5'd5, 32'h0);
        run_op(s, 2'd1, 2'd0, 1'b1, 32'h0000_0103, 32'h0, 0, 0, 32'h80AA_BBCC, 1'b0,
               lat, nreq, osig, ofault, baddr, bwdata, bwstrb, vcyc);
        check("lb_addr", baddr, 32'h0000_0100);
        check("lb_latency", lat, 3);
        check("lb_signed", osig.wdata, 32'hFFFF_FF80);
        idle(1);
        run_op(s, 2'd1, 2'd0, 1'b0, 32'h0000_0103, 32'h0, 0, 0, 32'h80AA_BBCC, 1'b0,
               lat, nreq, osig, ofault, baddr, bwdata, bwstrb, vcyc);
        check("lbu_unsigned", osig.wdata, 32'h0000_0080);
        idle(1);

        // half store with grant withheld 3 cycles
        s = mk_sig(32'h0000_100C, 5'd6, 32'h0000_7777);
        run_op(s, 2'd2, 2'd1, 1'b0, 32'h0000_0202, 32'hDEAD_BEEF, 3, 0, 32'h0, 1'b0,
               lat, nreq, osig, ofault, baddr, bwdata, bwstrb, vcyc);
        check("sh_wstrb", bwstrb, 4'b1100);
        check("sh_wdata", bwdata, 32'hBEEF_BEEF);
        check("sh_req_cycles", nreq, 4);
        check("sh_latency", lat, 5);
        check("sh_bundle", osig, s);
        idle(1);

        // back-to-back: store, then non-memory op in the store's o_valid cycle
        s = mk_sig(32'h0000_1010, 5'd7, 32'h0000_0001);
        run_op(s, 2'd2, 2'd2, 1'b0, 32'h0000_0040, 32'h1357_9BDF, 0, 0, 32'h0, 1'b0,
               lat, nreq, osig, ofault, baddr, bwdata, bwstrb, vcyc1);
        s = mk_sig(32'h0000_1014, 5'd8, 32'h0000_0002);
        run_op(s, 2'd0, 2'd0, 1'b0, 32'h0, 32'h0, 0, 0, 32'h0, 1'b0,
               lat, nreq, osig, ofault, baddr, bwdata, bwstrb, vcyc);
        check("b2b_gap", vcyc - vcyc1, 1);
        idle(2);

        // signed half load, stalled grant and data, stray rvalid during REQ
        s = mk_sig(32'h0000_1018, 5'd9, 32'h0);
        run_op(s, 2'd1, 2'd1, 1'b1, 32'h0000_0106, 32'h0, 1, 2, 32'h8001_7FFF, 1'b1,
               lat, nreq, osig, ofault, baddr, bwdata, bwstrb, vcyc);
        check("lh_signed", osig.wdata, 32'hFFFF_8001);
        check("lh_latency", lat, 6);
        idle(1);

        // byte store to lane 1
        s = mk_sig(32'h0000_101C, 5'd10, 32'h0);
        run_op(s, 2'd2, 2'd0, 1'b0, 32'h0000_0011, 32'h0000_0077, 0, 0, 32'h0, 1'b0,
               lat, nreq, osig, ofault, baddr, bwdata, bwstrb, vcyc);
        check("sb_wstrb", bwstrb, 4'b0010);
        check("sb_wdata", bwdata, 32'h7777_7777);
        idle(1);

        // misaligned word load at 0x301
        s = mk_sig(32'h0000_1020, 5'd11, 32'h0000_5555);
        run_op(s, 2'd1, 2'd2, 1'b0, 32'h0000_0301, 32'h0, 0, 0, 32'h1122_3344, 1'b0,
               lat, nreq, osig, ofault, baddr, bwdata, bwstrb, vcyc);
`ifdef MEM_MISALIGN_TRAP_EN
        check("mis_trap_latency", lat, 1);
        check("mis_trap_no_req", nreq, 0);
        check("mis_trap_fault", ofault, 1'b1);
        check("mis_trap_wback", osig.wback, 1'b0);
        check("mis_trap_wdata", osig.wdata, 32'h0000_5555);
`else
        check("mis_addr", baddr, 32'h0000_0300);
        check("mis_wdata", osig.wdata, 32'h1122_3344);
        check("mis_fault", ofault, 1'b0);
`endif
        idle(1);

        // misaligned half store at 0x203
        s = mk_sig(32'h0000_1024, 5'd12, 32'h0);
        run_op(s, 2'd2, 2'd1, 1'b0, 32'h0000_0203, 32'h0000_A5C3, 1, 0, 32'h0, 1'b0,
               lat, nreq, osig, ofault, baddr, bwdata, bwstrb, vcyc);
`ifdef MEM_MISALIGN_TRAP_EN
        check("mis_sh_fault", ofault, 1'b1);
`else
        check("mis_sh_wstrb", bwstrb, 4'b1100);
`endif
        idle(1);

        // pseudo-random mix, checked by the monitor and the model
        for (int k = 0; k < 24; k++) begin
            s = mk_sig($urandom, 5'($urandom_range(0, 31)), $urandom);
            run_op(s, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
                   1'($urandom_range(0, 1)), lat, nreq, osig, ofault, baddr, bwdata, bwstrb, vcyc);
        end
        idle(2);

        // reset while in WAIT, then a stray d_rvalid
        exp_baddr = 32'h0000_0104; exp_bwe = 1'b0; exp_bwstrb = 4'h0;
        i_valid = 1'b1; i_signals = mk_sig(32'h0000_1028, 5'd13, 32'h0);
        i_mem_op = 2'd1; i_mem_size = 2'd2; i_mem_signed = 1'b0; i_addr = 32'h0000_0104;
        @(posedge clk); #1;
        i_valid = 1'b0; d_gnt = 1'b1;
        @(posedge clk); #1;
        d_gnt = 1'b0;
        check("wait_not_ready", o_ready, 1'b0);
        rst = 1'b1;
        exp_q.delete();
        last_sig = '0;
        @(posedge clk); #1;
        rst = 1'b0; d_rvalid = 1'b1; d_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        check("rstw_d_req", d_req, 1'b0);
        check("rstw_o_valid", o_valid, 1'b0);
        check("rstw_o_ready", o_ready, 1'b1);
        check("rstw_o_signals", o_signals, 0);
        @(posedge clk); #1;
        d_rvalid = 1'b0;
        @(negedge clk);
        check("rstw_no_late_valid", o_valid, 1'b0);
        idle(2);
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage between Execute and the writeback stage. It accepts one instruction at a time from Execute and, for loads and stores, performs a single-outstanding transaction on the data-memory bus. It then presents the instruction's `Signals` bundle to writeback for exactly one cycle. Load data is aligned and extended here, so writeback sees final register data in `wdata`.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `i_valid`  in  1  Execute presents an instruction
- `o_ready`  out  1  stage can accept; high only in IDLE
- `i_signals`  in  Signals  bundle from Execute (pc, branch, cond, flags, wback, wreg, wdata)
- `i_mem_op`  in  2  0 = none, 1 = load, 2 = store, 3 = treated as none
- `i_mem_size`  in  2  0 = byte, 1 = half, 2 = word, 3 = treated as word
- `i_mem_signed`  in  1  sign-extend load result
- `i_addr`  in  32  byte address
- `i_store_data`  in  32  store data, right-justified
- `d_req`  out  1  bus request, held until `d_gnt`
- `d_we`  out  1  1 = store
- `d_addr`  out  32  `{addr[31:2], 2'b00}`
- `d_wstrb`  out  4  byte enables
- `d_wdata`  out  32  lane-replicated store data
- `d_gnt`  in  1  request accepted
- `d_rvalid`  in  1  read data valid
- `d_rdata`  in  32  read word
- `o_valid`  out  1  one-cycle pulse; `o_signals` is valid
- `o_signals`  out  Signals  bundle to writeback
- `o_fault`  out  1  misaligned-access fault, qualified by `o_valid`

## Operation
- States: IDLE, REQ, WAIT.
- Capture: when `i_valid && o_ready`, latch `i_signals`, op, size, signed, addr and store data into internal registers.
- No memory op, from IDLE:
  - Next cycle: `o_valid=1` and `o_signals=i_signals`.
  - State stays IDLE.
- Load or store, from IDLE: go to REQ.
- REQ state:
  - `d_req=1`. `d_we`, `d_addr`, `d_wstrb` and `d_wdata` come from the latched registers and stay stable until `d_gnt`.
  - On `d_gnt` for a store: go to IDLE and pulse `o_valid` next cycle with the bundle unchanged.
  - On `d_gnt` for a load: go to WAIT.
- WAIT state: on `d_rvalid`, write the formatted load data into `o_signals.wdata`, pulse `o_valid` next cycle, and go to IDLE.
- `d_rvalid` in IDLE or REQ is ignored.
- Byte lane select is `lane = addr[1:0]`:
  - Byte: `d_wstrb = 4'b0001 << lane`; `d_wdata = {4{sd[7:0]}}`.
  - Half: `d_wstrb = 4'b0011 << lane`; `d_wdata = {2{sd[15:0]}}`.
  - Word: `d_wstrb = 4'hF`; `d_wdata = sd`.
  - Loads: `d_wstrb = 0`.
- Load formatting:
  - Select the byte or half at `lane` from `d_rdata`.
  - Sign-extend if `i_mem_signed`, otherwise zero-extend, to 32 bits.
  - Word loads pass through unchanged.
- Misaligned cases: half with `addr[0]=1`; word with `addr[1:0]!=0`. Behaviour is set by Configuration.
- `o_signals` holds its last value when `o_valid=0`.

## Timing
- Reset values: state IDLE, `o_valid=0`, `o_fault=0`, `o_signals` all-zero. `d_req=0`, `d_we=0`, `d_wstrb=0`.
- `o_ready` is combinational: `state == IDLE`.
- `d_*` outputs are combinational from state and latched registers.
- Latency, counted from accept in cycle 0 to `o_valid`:
  - Non-memory op: cycle 1.
  - Store with `d_gnt` in cycle 1: cycle 2.
  - Load with `d_gnt` in cycle 1 and `d_rvalid` in cycle 2: cycle 3 (minimum).
- Each wait cycle on `d_gnt` or `d_rvalid` adds one cycle.
- Back-to-back: a new instruction can be accepted in the same cycle that `o_valid` pulses for the previous one.
- Reset mid-transaction: the transaction is abandoned. The cycle after the reset edge, `d_req=0` and no `o_valid` is produced; a late `d_rvalid` is ignored.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined:
  - A misaligned load or store issues no bus request.
  - Next cycle: `o_valid=1`, `o_fault=1`, `o_signals.wback=0`; all other fields are passed through.
  - State stays IDLE.
- `MEM_MISALIGN_TRAP_EN` undefined:
  - `o_fault` is tied 0.
  - Misaligned accesses round down: half uses lane `{addr[1],1'b0}`, word uses lane 0.
  - The access then proceeds normally.

## Test plan
- Non-memory op: `i_mem_op=0`, `wdata=0x1234` -> `o_valid` in cycle 1 with `wdata=0x1234`; `d_req` never asserts.
- Signed byte load: addr `0x103`, `d_rdata=0x80AABBCC` returned one cycle after grant -> `d_addr=0x100`, `o_valid` in cycle 3, `wdata=0xFFFFFF80`. The same case unsigned gives `0x00000080`.
- Half store with stalled grant: addr `0x202`, data `0xDEADBEEF`, `d_gnt` withheld 3 cycles -> `d_req` held with stable `d_wstrb=4'b1100` and `d_wdata=0xBEEFBEEF`; `o_valid` on the cycle after grant.
- Back-to-back: a store is followed immediately by a non-memory op -> the op is accepted in the store's `o_valid` cycle; two `o_valid` pulses occur in consecutive cycles.
- Misaligned word load at `0x301`:
  - With `MEM_MISALIGN_TRAP_EN`: no `d_req`, `o_valid` and `o_fault` in cycle 1, `wback=0`.
  - Without it: `d_addr=0x300` and the full word is returned.
- Reset while in WAIT: assert `rst` for one cycle, then drive a stray `d_rvalid` -> no `o_valid`, `o_ready=1`, `o_signals=0`.
